// File: rtl/apb_initiator_if.sv
// Request/response and APB bus signals of the APB initiator, grouped for port use.
// The master modport is the initiator's view; slave is the requester/responder side.
interface apb_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_prot;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] out_paddr;
    logic        out_psel;
    logic        out_penable;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
        input  resp_ready, out_pready, out_prdata, out_pslverr,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
        output resp_ready, out_pready, out_prdata, out_pslverr,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb
    );
endinterface

// File: rtl/apb_initiator.sv
// Single-outstanding APB4 master: turns a valid/ready request into SETUP/ACCESS
// phases, waits for PREADY with an optional timeout, and returns a response.
module apb_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic             clock,
    input logic             reset,
    apb_initiator_if.master bus
);
    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic          write_q, write_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [2:0]    prot_q, prot_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            prot_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            prot_q  <= prot_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        prot_d  = prot_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    write_d = bus.req_write;
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    prot_d  = bus.req_prot;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (bus.out_pready) begin
                    rdata_d = write_q ? '0 : bus.out_prdata;
                    err_d   = bus.out_pslverr;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != '1) begin
                    // Saturate so a disabled timeout never wraps back into range.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.resp_valid  = (state_q == RESP);
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;
    assign bus.out_psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.out_penable = (state_q == ACCESS);
    assign bus.out_paddr   = addr_q;
    assign bus.out_pwrite  = write_q;
    assign bus.out_pwdata  = wdata_q;
    assign bus.out_pprot   = prot_q;
    assign bus.out_pstrb   = write_q ? wstrb_q : 4'b0000;
endmodule

// File: tb/tb_apb_initiator.sv
// Self-checking bench for apb_initiator: directed and random transfers against a
// transaction-level model of wait states, timeout, error and response handshake.
module tb_apb_initiator;
    localparam int unsigned TO = 4;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    apb_initiator_if bus ();
    apb_initiator_if bus0 ();

    apb_initiator #(.TIMEOUT(TO)) dut (.clock(clock), .reset(reset), .bus(bus.master));
    apb_initiator #(.TIMEOUT(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0.master));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One full transfer on the TIMEOUT=4 instance. Entered and left #1 after an edge.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int unsigned waits,
                        input logic [31:0] prdata, input logic slverr, input int unsigned hold,
                        input logic keep_next, input logic [31:0] next_addr);
        int unsigned n;
        int unsigned exp_n;
        logic        done;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_strb;
        exp_n     = (waits >= TO) ? TO : waits + 1;
        exp_err   = (waits >= TO) ? 1'b1 : slverr;
        exp_rdata = (waits >= TO || wr) ? 32'h0 : prdata;
        exp_strb  = wr ? strb : 4'h0;

        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_wstrb = strb; bus.req_prot = prot;
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++; $display("FAIL idle_req_ready got=%b want=1", bus.req_ready);
        end
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        bus.out_pready = 1'b1;  // must be ignored during SETUP
        bus.out_prdata = $urandom;
        vectors++;
        if ({bus.out_psel, bus.out_penable, bus.req_ready, bus.resp_valid} !== 4'b1000) begin
            miscompares++;
            $display("FAIL setup_ctrl got sel/en/rr/rv=%b%b%b%b want=1000", bus.out_psel,
                     bus.out_penable, bus.req_ready, bus.resp_valid);
        end
        n = 0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clock); #1;
            if (bus.resp_valid === 1'b1) done = 1'b1;
            else begin
                n++;
                vectors++;
                if ({bus.out_psel, bus.out_penable, bus.out_paddr, bus.out_pwrite, bus.out_pwdata,
                     bus.out_pstrb, bus.out_pprot} !== {2'b11, addr, wr, wdata, exp_strb, prot}) begin
                    miscompares++;
                    $display("FAIL access_bus cycle=%0d got sel=%b en=%b addr=%h wr=%b wd=%h strb=%h prot=%h want addr=%h wr=%b wd=%h strb=%h prot=%h",
                             n, bus.out_psel, bus.out_penable, bus.out_paddr, bus.out_pwrite,
                             bus.out_pwdata, bus.out_pstrb, bus.out_pprot, addr, wr, wdata, exp_strb, prot);
                end
                bus.out_pready  = (n > waits);
                bus.out_prdata  = (n > waits) ? prdata : $urandom;
                bus.out_pslverr = (n > waits) ? slverr : 1'($urandom);
            end
        end
        bus.out_pready = 1'($urandom); bus.out_prdata = $urandom; bus.out_pslverr = 1'($urandom);
        vectors++;
        if (!done || n != exp_n) begin
            miscompares++; $display("FAIL access_cycles got=%0d done=%b want=%0d", n, done, exp_n);
        end
        vectors++;
        if ({bus.out_psel, bus.out_penable, bus.req_ready, bus.resp_rdata, bus.resp_err} !==
            {3'b000, exp_rdata, exp_err}) begin
            miscompares++;
            $display("FAIL resp_data got sel=%b en=%b rr=%b rdata=%h err=%b want rdata=%h err=%b",
                     bus.out_psel, bus.out_penable, bus.req_ready, bus.resp_rdata, bus.resp_err,
                     exp_rdata, exp_err);
        end
        bus.resp_ready = 1'b0;
        if (keep_next) begin
            bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = next_addr;
        end
        for (int h = 0; h < int'(hold); h++) begin
            @(posedge clock); #1;
            bus.out_pready = 1'($urandom);
            vectors++;
            if ({bus.resp_valid, bus.out_psel, bus.req_ready, bus.resp_rdata, bus.resp_err} !==
                {3'b100, exp_rdata, exp_err}) begin
                miscompares++;
                $display("FAIL resp_hold h=%0d got rv=%b sel=%b rr=%b rdata=%h err=%b want rdata=%h err=%b",
                         h, bus.resp_valid, bus.out_psel, bus.req_ready, bus.resp_rdata,
                         bus.resp_err, exp_rdata, exp_err);
            end
        end
        bus.resp_ready = 1'b1;
        @(posedge clock); #1;
        bus.resp_ready = 1'b0;
        bus.out_pready = 1'b0;
        vectors++;
        if ({bus.resp_valid, bus.req_ready, bus.out_psel} !== 3'b010) begin
            miscompares++;
            $display("FAIL after_handshake got rv=%b rr=%b sel=%b want 0/1/0", bus.resp_valid,
                     bus.req_ready, bus.out_psel);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if ({bus.req_ready, bus.resp_valid, bus.out_psel, bus.out_penable, bus.out_paddr,
             bus.out_pwrite, bus.out_pwdata, bus.out_pstrb, bus.out_pprot, bus.resp_rdata,
             bus.resp_err} !== {1'b1, 108'h0}) begin
            miscompares++;
            $display("FAIL reset_outputs got rr=%b rv=%b sel=%b en=%b addr=%h err=%b", bus.req_ready,
                     bus.resp_valid, bus.out_psel, bus.out_penable, bus.out_paddr, bus.resp_err);
        end
        reset = 1'b1;
    endtask

    task automatic test_write_zero_wait();
        xfer(1'b1, 32'h1000_0000, 32'h0000_A5A5, 4'hF, 3'h0, 0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_read_waits();
        xfer(1'b0, 32'h1000_0004, 32'h1234_5678, 4'h3, 3'h2, 3, 32'h0000_00F0, 1'b0, 1, 1'b0, 32'h0);
    endtask

    task automatic test_slverr();
        xfer(1'b0, 32'h1000_0008, 32'h0, 4'h0, 3'h1, 1, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, 32'h0);
    endtask

    task automatic test_timeout();
        xfer(1'b0, 32'h2000_0000, 32'h0, 4'h0, 3'h0, 50, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 32'h0);
        xfer(1'b1, 32'h2000_0010, 32'h5555_AAAA, 4'h6, 3'h4, TO, 32'h0, 1'b0, 2, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        xfer(1'b1, 32'h3000_0000, 32'h0BAD_F00D, 4'hC, 3'h3, 0, 32'h0, 1'b0, 5, 1'b1, 32'h3000_0040);
        xfer(1'b0, 32'h3000_0040, 32'h0BAD_F00D, 4'hC, 3'h3, 2, 32'h7777_1111, 1'b0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_no_timeout();
        int bad;
        bad = 0;
        bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = 32'h4000_0000;
        @(posedge clock); #1;
        bus0.req_valid = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clock); #1;
            if ({bus0.out_psel, bus0.out_penable, bus0.resp_valid} !== 3'b110) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++; $display("FAIL no_timeout_wait got bad_cycles=%0d want=0", bad);
        end
        bus0.out_pready = 1'b1; bus0.out_prdata = 32'h0000_1234; bus0.out_pslverr = 1'b0;
        @(posedge clock); #1;
        bus0.out_pready = 1'b0;
        vectors++;
        if ({bus0.resp_valid, bus0.resp_err, bus0.resp_rdata} !== {2'b10, 32'h0000_1234}) begin
            miscompares++;
            $display("FAIL no_timeout_resp got rv=%b err=%b rdata=%h want 1/0/00001234",
                     bus0.resp_valid, bus0.resp_err, bus0.resp_rdata);
        end
        bus0.resp_ready = 1'b1;
        @(posedge clock); #1;
        bus0.resp_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h5000_0000;
        bus.req_wdata = 32'hFFFF_0000; bus.req_wstrb = 4'hF; bus.req_prot = 3'h7;
        @(posedge clock); #1;
        bus.req_valid = 1'b0; bus.out_pready = 1'b0;
        @(posedge clock); #1;
        vectors++;
        if ({bus.out_psel, bus.out_penable} !== 2'b11) begin
            miscompares++; $display("FAIL pre_reset_access got sel/en=%b%b want=11", bus.out_psel, bus.out_penable);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.out_psel, bus.out_penable, bus.req_ready, bus.resp_valid, bus.out_paddr,
             bus.out_pwrite, bus.out_pstrb} !== {4'b0010, 32'h0, 1'b0, 4'h0}) begin
            miscompares++;
            $display("FAIL async_reset got sel=%b en=%b rr=%b rv=%b addr=%h wr=%b strb=%h want 0/0/1/0/0/0/0",
                     bus.out_psel, bus.out_penable, bus.req_ready, bus.resp_valid, bus.out_paddr,
                     bus.out_pwrite, bus.out_pstrb);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        vectors++;
        if ({bus.req_ready, bus.resp_valid, bus.out_psel} !== 3'b100) begin
            miscompares++;
            $display("FAIL post_reset got rr=%b rv=%b sel=%b want 1/0/0", bus.req_ready, bus.resp_valid, bus.out_psel);
        end
        xfer(1'b1, 32'h5000_0004, 32'h1357_9BDF, 4'h5, 3'h2, 1, 32'h0, 1'b0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
                 $urandom_range(0, 5), $urandom, 1'($urandom), $urandom_range(0, 2), 1'b0, 32'h0);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_wdata = '0;
        bus.req_wstrb = '0; bus.req_prot = '0; bus.resp_ready = 1'b0;
        bus.out_pready = 1'b0; bus.out_prdata = '0; bus.out_pslverr = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.req_write = 1'b0; bus0.req_wdata = '0;
        bus0.req_wstrb = '0; bus0.req_prot = '0; bus0.resp_ready = 1'b0;
        bus0.out_pready = 1'b0; bus0.out_prdata = '0; bus0.out_pslverr = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_no_timeout();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
